// File: rtl/water_grid_controller.sv
// Reservoir supply controller: per-zone populations, rationing FSM with hysteresis,
// delayed treated-water return and saturating rain inflow into a clamped reservoir level.
module water_grid_controller #(
  parameter int NUM_ZONES    = 4,
  parameter int POP_W        = 8,
  parameter int RATE_W       = 4,
  parameter int LEVEL_W      = 12,
  parameter int MAX_LEVEL    = 4000,
  parameter int INIT_LEVEL   = 2000,
  parameter int INIT_POP     = 50,
  parameter int RET_NUM      = 9,
  parameter int TREAT_LAT    = 3,
  parameter int RATION_MARK  = 800,
  parameter int CRIT_MARK    = 400,
  parameter int RECOVER_MARK = 1600
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_ZONES-1:0]        zone_add,
  input  logic [NUM_ZONES-1:0]        zone_sub,
  input  logic [NUM_ZONES*RATE_W-1:0] zone_rate,
  input  logic                        rain_add,
  input  logic [5:0]                  collection_rate,
  output logic [NUM_ZONES*POP_W-1:0]  zone_pop,
  output logic [NUM_ZONES-1:0]        zone_served,
  output logic [LEVEL_W-1:0]          reservoir_level,
  output logic [1:0]                  supply_state,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int DEM_W = POP_W + $clog2(NUM_ZONES);
  localparam int SUM_W = LEVEL_W + 2;

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    RATION   = 2'd1,
    CRITICAL = 2'd2
  } state_t;

  state_t             state, state_next;
  logic               phase;
  logic [POP_W-1:0]   pop      [NUM_ZONES];
  logic [POP_W-1:0]   pop_next [NUM_ZONES];
  logic [DEM_W-1:0]   treat_pipe [TREAT_LAT];

  logic [RATE_W-1:0]  rate_i;
  logic [POP_W:0]     pop_up;
  logic [DEM_W-1:0]   demand;
  logic [DEM_W-1:0]   draw;
  logic               short_supply;
  logic [DEM_W+4:0]   ret_prod;
  logic [DEM_W-1:0]   ret_in;
  logic [6:0]         rain;
  logic [SUM_W-1:0]   level_sum;
  logic [LEVEL_W-1:0] level_next;

  // Saturating population update; the carry bit of pop_up flags an add past full scale.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rate_i = '0;
    pop_up = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      rate_i      = zone_rate[i*RATE_W +: RATE_W];
      pop_up      = {1'b0, pop[i]} + (POP_W+1)'(rate_i);
      pop_next[i] = pop[i];
      if (zone_add[i] && !zone_sub[i]) begin
        pop_next[i] = pop_up[POP_W] ? '1 : pop_up[POP_W-1:0];
      end else if (zone_sub[i] && !zone_add[i]) begin
        pop_next[i] = (pop[i] < POP_W'(rate_i)) ? '0 : pop[i] - POP_W'(rate_i);
      end
    end
  end

  // Supply FSM decides on the registered level, so transitions lag a crossing by one cycle.
  always_comb begin
    state_next  = state;
    zone_served = '0;
    case (state)
      NORMAL: begin
        zone_served = '1;
        if (reservoir_level < LEVEL_W'(RATION_MARK)) state_next = RATION;
      end
      RATION: begin
        for (int i = 0; i < NUM_ZONES; i++) zone_served[i] = (1'(i) == phase);
        if (reservoir_level < LEVEL_W'(CRIT_MARK))          state_next = CRITICAL;
        else if (reservoir_level >= LEVEL_W'(RECOVER_MARK)) state_next = NORMAL;
      end
      CRITICAL: begin
        if (reservoir_level >= LEVEL_W'(RATION_MARK)) state_next = RATION;
      end
      default: state_next = NORMAL;
    endcase
  end

  // A draw is all-or-nothing; since draw never exceeds level, the sum cannot go negative.
  always_comb begin
    demand = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      if (zone_served[i]) demand = demand + DEM_W'(pop[i]);
    end
    short_supply = SUM_W'(demand) > SUM_W'(reservoir_level);
    draw         = short_supply ? '0 : demand;
    ret_prod     = (DEM_W+5)'(draw) * (DEM_W+5)'(RET_NUM);
    ret_in       = ret_prod[DEM_W+3:4];
    rain         = rain_add ? {collection_rate, 1'b0} : '0;
    level_sum    = SUM_W'(reservoir_level) - SUM_W'(draw)
                 + SUM_W'(treat_pipe[TREAT_LAT-1]) + SUM_W'(rain);
    level_next   = (level_sum > SUM_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL)
                                                   : level_sum[LEVEL_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= NORMAL;
      phase           <= 1'b0;
      reservoir_level <= LEVEL_W'(INIT_LEVEL);
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      // NOTE: the pipeline array is reset on purpose so in-flight water is discarded on reset.
      for (int i = 0; i < NUM_ZONES; i++) pop[i] <= POP_W'(INIT_POP);
      for (int j = 0; j < TREAT_LAT; j++) treat_pipe[j] <= '0;
    end else begin
      state           <= state_next;
      phase           <= (state == RATION) ? ~phase : 1'b0;
      reservoir_level <= level_next;
      overflow        <= (level_next == LEVEL_W'(MAX_LEVEL));
      underflow       <= short_supply;
      for (int i = 0; i < NUM_ZONES; i++) pop[i] <= pop_next[i];
      treat_pipe[0] <= ret_in;
      for (int j = 1; j < TREAT_LAT; j++) treat_pipe[j] <= treat_pipe[j-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ZONES; i++) zone_pop[i*POP_W +: POP_W] = pop[i];
  end

  assign supply_state = state;

endmodule

// File: tb/tb_water_grid_controller.sv
// Scoreboard bench for water_grid_controller: a behavioural reservoir model predicts each
// cycle's outputs into a queue; a monitor pops and compares after every rising edge.
module tb_water_grid_controller;

  localparam int NZ = 4;

  logic          clk;
  logic          reset;
  logic [NZ-1:0] zone_add;
  logic [NZ-1:0] zone_sub;
  logic [15:0]   zone_rate;
  logic          rain_add;
  logic [5:0]    collection_rate;
  logic [31:0]   zone_pop;
  logic [NZ-1:0] zone_served;
  logic [11:0]   reservoir_level;
  logic [1:0]    supply_state;
  logic          overflow;
  logic          underflow;

  water_grid_controller dut (
    .clk             (clk),
    .reset           (reset),
    .zone_add        (zone_add),
    .zone_sub        (zone_sub),
    .zone_rate       (zone_rate),
    .rain_add        (rain_add),
    .collection_rate (collection_rate),
    .zone_pop        (zone_pop),
    .zone_served     (zone_served),
    .reservoir_level (reservoir_level),
    .supply_state    (supply_state),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pops;
    logic [3:0]  served;
    int          level;
    int          state;
    int          ov;
    int          uf;
    int          cyc;
  } sb_item_t;

  sb_item_t sb_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: plain integers, a FIFO of scheduled returns.
  int m_pop[NZ];
  int m_level, m_state, m_phase;
  int m_ret[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int served_of(input int st, input int ph);
    int s = 0;
    if (st == 0) s = 4'hF;
    else if (st == 1) begin
      for (int i = 0; i < NZ; i++) if ((i % 2) == ph) s |= (1 << i);
    end
    return s;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NZ; i++) m_pop[i] = 50;
    m_level = 2000;
    m_state = 0;
    m_phase = 0;
    m_ret.delete();
    for (int i = 0; i < 3; i++) m_ret.push_back(0);
  endfunction

  // Called at a falling edge: drive inputs, predict the post-edge outputs, wait one cycle.
  task automatic step(input logic [3:0] add, input logic [3:0] sub, input logic [15:0] rate,
                      input logic rain, input logic [5:0] cr);
    sb_item_t e;
    int served, demand, draw, ret_out, nl, ns, r;
    zone_add = add; zone_sub = sub; zone_rate = rate;
    rain_add = rain; collection_rate = cr;

    served = served_of(m_state, m_phase);
    demand = 0;
    for (int i = 0; i < NZ; i++) if ((served >> i) & 1) demand += m_pop[i];
    draw    = (demand <= m_level) ? demand : 0;
    ret_out = m_ret.pop_front();
    m_ret.push_back((draw * 9) / 16);
    nl = m_level - draw + ret_out + (rain ? 2 * int'(cr) : 0);
    if (nl > 4000) nl = 4000;
    if (nl < 0) nl = 0;

    case (m_state)
      0:       ns = (m_level < 800) ? 1 : 0;
      1:       ns = (m_level < 400) ? 2 : ((m_level >= 1600) ? 0 : 1);
      default: ns = (m_level >= 800) ? 1 : 2;
    endcase
    if (m_state == 1 && ns == 1) m_phase ^= 1;
    else if (ns == 1) m_phase = 0;

    for (int i = 0; i < NZ; i++) begin
      r = int'(rate[i*4 +: 4]);
      if (add[i] && !sub[i])      m_pop[i] = (m_pop[i] + r > 255) ? 255 : m_pop[i] + r;
      else if (sub[i] && !add[i]) m_pop[i] = (m_pop[i] - r < 0) ? 0 : m_pop[i] - r;
    end

    e.uf    = (demand > m_level) ? 1 : 0;
    m_level = nl;
    m_state = ns;
    for (int i = 0; i < NZ; i++) e.pops[i*8 +: 8] = 8'(m_pop[i]);
    e.served = 4'(served_of(m_state, m_phase));
    e.level  = m_level;
    e.state  = m_state;
    e.ov     = (m_level == 4000) ? 1 : 0;
    e.cyc    = cyc;
    sb_q.push_back(e);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'h0, 4'h0, 16'h0, 1'b0, 6'd0);
  endtask

  // Called at a falling edge; asynchronous reset must take effect before the next edge.
  task automatic do_reset();
    reset = 1'b0;
    zone_add = '0; zone_sub = '0; zone_rate = '0; rain_add = 1'b0; collection_rate = '0;
    #1;
    model_reset();
    check("rst_level",     32'(reservoir_level), 32'd2000);
    check("rst_state",     32'(supply_state),    32'd0);
    check("rst_overflow",  32'(overflow),        32'd0);
    check("rst_underflow", 32'(underflow),       32'd0);
    check("rst_pops",      zone_pop,             32'h32323232);
    check("rst_served",    32'(zone_served),     32'hF);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : monitor
    sb_item_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check($sformatf("pops@%0d", e.cyc),      zone_pop,                 e.pops);
        check($sformatf("served@%0d", e.cyc),    32'(zone_served),         32'(e.served));
        check($sformatf("level@%0d", e.cyc),     32'(reservoir_level),     e.level);
        check($sformatf("state@%0d", e.cyc),     32'(supply_state),        e.state);
        check($sformatf("overflow@%0d", e.cyc),  32'(overflow),            e.ov);
        check($sformatf("underflow@%0d", e.cyc), 32'(underflow),           e.uf);
      end
    end
  end

  initial begin : stimulus
    reset = 1'b1;
    zone_add = '0; zone_sub = '0; zone_rate = '0; rain_add = 1'b0; collection_rate = '0;
    model_reset();
    #2;
    do_reset();

    // Idle drain with delayed treated return.
    idle(4);
    check("t1_level_1312", 32'(reservoir_level), 32'd1312);
    check("t1_state",      32'(supply_state),    32'd0);
    check("t1_underflow",  32'(underflow),       32'd0);
    idle(2);

    // Saturating add, floored sub, add&sub hold, neither hold.
    for (int k = 0; k < 20; k++) step(4'b0101, 4'b0110, 16'hFFFF, 1'b0, 6'd0);
    check("t2_pop0_sat",  32'(zone_pop[7:0]),   32'd255);
    check("t2_pop1_zero", 32'(zone_pop[15:8]),  32'd0);
    check("t2_pop2_hold", 32'(zone_pop[23:16]), 32'd50);

    // Heavy demand drives the level through RATION towards CRITICAL with underflows.
    for (int k = 0; k < 15; k++) step(4'hF, 4'h0, 16'hFFFF, 1'b0, 6'd0);
    idle(40);

    // Zero demand and maximum rain: level saturates at capacity.
    for (int k = 0; k < 60; k++) step(4'h0, 4'hF, 16'hFFFF, 1'b1, 6'd63);
    check("t4_level_max", 32'(reservoir_level), 32'd4000);
    check("t4_overflow",  32'(overflow),        32'd1);
    for (int k = 0; k < 4; k++) step(4'h1, 4'h0, 16'h0005, 1'b0, 6'd0);
    idle(1);

    // Reset with treated water in flight; no stale return afterwards.
    do_reset();
    idle(1);
    check("t6_level_1800", 32'(reservoir_level), 32'd1800);
    idle(3);
    check("t6_level_1312", 32'(reservoir_level), 32'd1312);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(4'($urandom), 4'($urandom), 16'($urandom),
                ($urandom_range(0, 2) != 0), 6'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
